// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined W-bit adder/subtractor split into S carry-chain slices.
// Optional ADDSUB_SAT_EN: clamp s to the signed extreme on overflow.
module addsub_pipe #(
  parameter int W = 8,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  localparam int K = W / S;

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar i = 0; i < S; i++) begin : stg
    // Operands shrink by one slice per stage; the result grows by one slice.
    localparam int IW = W - i * K;

    logic [IW-1:0]        a_s;
    logic [IW-1:0]        b_s;
    logic                 c_s;
    logic                 v_s;
    logic [(i+1)*K-1:0]   r_s;
    logic [K-1:0]         g;
    logic [K-1:0]         p;
    logic [K-1:0]         sum;
    logic [K:0]           cy;
    logic                 v_q;

    if (i == 0) begin : src
      assign a_s = a;
      assign b_s = b ^ {W{sub}};
      assign c_s = cin ^ sub;
      assign v_s = in_valid;
      assign r_s = sum;
    end else begin : src
      assign a_s = stg[i-1].skw.a_q;
      assign b_s = stg[i-1].skw.b_q;
      assign c_s = stg[i-1].skw.c_q;
      assign v_s = stg[i-1].v_q;
      assign r_s = {sum, stg[i-1].skw.r_q};
    end

    always_comb begin
      g     = a_s[K-1:0] & b_s[K-1:0];
      p     = a_s[K-1:0] ^ b_s[K-1:0];
      cy    = '0;
      cy[0] = c_s;
      for (int j = 0; j < K; j++) begin
        cy[j+1] = g[j] | (p[j] & cy[j]);
      end
      sum = p ^ cy[K-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (advance) begin
        v_q <= v_s;
      end
    end

    if (i < S - 1) begin : skw
      logic [IW-K-1:0]    a_q;
      logic [IW-K-1:0]    b_q;
      logic               c_q;
      logic [(i+1)*K-1:0] r_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          r_q <= '0;
        end else if (advance) begin
          a_q <= a_s[IW-1:K];
          b_q <= b_s[IW-1:K];
          c_q <= cy[K];
          r_q <= r_s;
        end
      end
    end else begin : fin
      logic [W-1:0] s_d;
      logic         ovf_d;
      logic [W-1:0] s_q;
      logic         cout_q;
      logic         ovf_q;
      logic         zero_q;
      logic         neg_q;

      always_comb begin
        ovf_d = (a_s[K-1] == b_s[K-1]) && (r_s[W-1] != a_s[K-1]);
        s_d   = r_s;
`ifdef ADDSUB_SAT_EN
        if (ovf_d) begin
          s_d = a_s[K-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q    <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (advance) begin
          s_q    <= s_d;
          cout_q <= cy[K];
          ovf_q  <= ovf_d;
          zero_q <= (s_d == '0);
          neg_q  <= s_d[W-1];
        end
      end
    end
  end

  assign out_valid = stg[S-1].v_q;
  assign s         = stg[S-1].fin.s_q;
  assign cout      = stg[S-1].fin.cout_q;
  assign ovf       = stg[S-1].fin.ovf_q;
  assign zero      = stg[S-1].fin.zero_q;
  assign neg       = stg[S-1].fin.neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - self-checking bench for addsub_pipe against an integer-arithmetic model.
module tb_addsub_pipe;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  int errors = 0;
  int checks = 0;

  logic [W+3:0] exp_q[$];
  logic         hold_v = 1'b0;
  logic [W+4:0] hold_val = '0;

  localparam logic [W-1:0] ONES   = {W{1'b1}};
  localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINNEG = {1'b1, {(W-1){1'b0}}};

  addsub_pipe #(.W(W), .S(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference: signed/unsigned integer arithmetic, result packed as {cout, ovf, zero, neg, s}.
  function automatic logic [W+3:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                         input logic xs, input logic xc);
    longint one, ua, ub, sa, sb, ci, sm, tru, mx, mn;
    logic         co, ov;
    logic [W-1:0] sv;
    one = 1;
    ua  = longint'(xa);
    ub  = longint'(xb);
    ci  = xc ? 1 : 0;
    sa  = xa[W-1] ? ua - (one << W) : ua;
    sb  = xb[W-1] ? ub - (one << W) : ub;
    mx  = (one << (W - 1)) - 1;
    mn  = -(one << (W - 1));
    if (!xs) begin
      sm  = ua + ub + ci;
      co  = sm >= (one << W);
      tru = sa + sb + ci;
    end else begin
      sm  = ua - ub - ci;
      co  = ua >= ub + ci;
      tru = sa - sb - ci;
    end
    sv = sm[W-1:0];
    ov = (tru > mx) || (tru < mn);
`ifdef ADDSUB_SAT_EN
    if (tru > mx) sv = mx[W-1:0];
    else if (tru < mn) sv = mn[W-1:0];
`endif
    return {co, ov, (sv == '0), sv[W-1], sv};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return ONES;
      2:       return MAXPOS;
      3:       return MINNEG;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, then let the posedge happen.
  // lat >= 0 additionally requires out_valid == lat this cycle.
  task automatic cyc(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic isub, input logic icin, input logic ordy, input int lat,
                     output logic acc);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sub       = isub;
    cin       = icin;
    out_ready = ordy;
    #1;
    if (hold_v) chk("hold_stable", 64'({out_valid, cout, ovf, zero, neg, s}), 64'(hold_val));
    chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    if (lat >= 0) chk("latency_valid", 64'(out_valid), 64'(lat));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'(0));
      else chk("result", 64'({cout, ovf, zero, neg, s}), 64'(exp_q.pop_front()));
    end
    hold_v   = out_valid && !out_ready;
    hold_val = {out_valid, cout, ovf, zero, neg, s};
    acc      = iv && in_ready;
    if (acc) exp_q.push_back(model(ia, ib, isub, icin));
    @(posedge clk);
  endtask

  task automatic single(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic icin);
    logic acc;
    cyc(1'b1, ia, ib, isub, icin, 1'b1, -1, acc);
    chk("single_accept", 64'(acc), 64'(1));
    for (int k = 1; k <= S; k++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, (k == S) ? 1 : 0, acc);
    end
  endtask

  initial begin
    logic         acc;
    logic [W-1:0] ra, rb;
    logic         rs, rc;
    int           sent, n;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 64'({out_valid, cout, ovf, zero, neg, s}), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;

    single(W'(1),   W'(200), 1'b0, 1'b0);
    single(W'(200), W'(100), 1'b0, 1'b0);
    single(ONES,    '0,      1'b0, 1'b1);
    single(ONES,    ONES,    1'b0, 1'b1);
    single(MAXPOS,  W'(1),   1'b0, 1'b0);
    single(MINNEG,  W'(1),   1'b1, 1'b0);
    single(W'(5),   W'(7),   1'b1, 1'b0);
    single(W'(7),   W'(5),   1'b1, 1'b1);
    single('0,      '0,      1'b1, 1'b0);
    single('0,      '0,      1'b1, 1'b1);
    single(MINNEG,  MINNEG,  1'b0, 1'b0);

    // Stream of 10 beats under a 1,0,0 out_ready pattern.
    sent = 0; n = 0;
    ra = rnd_op(); rb = rnd_op(); rs = 1'($urandom); rc = 1'($urandom);
    while (sent < 10 && n < 200) begin
      cyc(1'b1, ra, rb, rs, rc, (n % 3 == 0), -1, acc);
      if (acc) begin
        sent++;
        ra = rnd_op(); rb = rnd_op(); rs = 1'($urandom); rc = 1'($urandom);
      end
      n++;
    end
    chk("stream_sent", 64'(sent), 64'(10));
    repeat (S + 2) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, -1, acc);
    chk("stream_drained", 64'(exp_q.size()), 64'(0));

    // Reset with beats in flight discards them.
    cyc(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b1, -1, acc);
    cyc(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b1, 1'b1, -1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midreset_outputs", 64'({out_valid, cout, ovf, zero, neg, s}), 64'(0));
    chk("midreset_in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    single(W'(3), W'(4), 1'b0, 1'b1);

    // Random traffic with random backpressure.
    for (int t = 0; t < 400; t++) begin
      cyc($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom),
          $urandom_range(0, 3) != 0, -1, acc);
    end
    repeat (S + 4) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, -1, acc);
    chk("random_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
